parking_occupancy_ctrl: RTL and testbench

//  Multi-lane parking occupancy controller. Each lane has an outer sensor a and an inner sensor b.
//  Per lane: synchronise and debounce both sensors, then decode direction with a sequence FSM.
//  Net entries/exits across all lanes drive a saturating occupancy counter with full/empty/error flags.
//  Its count output feeds the LED and display logic at the top level.

---
 rtl/parking_pkg.sv | 30 +++
 rtl/parking_occupancy_ctrl_if.sv | 29 ++
 rtl/lane_dir_fsm.sv | 154 +++++++++++++++
 rtl/parking_occupancy_ctrl.sv | 106 ++++++++++
 tb/tb_parking_occupancy_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/parking_pkg.sv
// Shared types for the parking occupancy controller: lane FSM states,
// sensor codes (written {a,b}) and a small popcount helper.
package parking_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EN1   = 3'd1,
    ST_EN2   = 3'd2,
    ST_EN3   = 3'd3,
    ST_EX1   = 3'd4,
    ST_EX2   = 3'd5,
    ST_EX3   = 3'd6,
    ST_ABORT = 3'd7
  } lane_state_e;

  localparam logic [1:0] SNS_NONE = 2'b00;
  localparam logic [1:0] SNS_B    = 2'b01;
  localparam logic [1:0] SNS_A    = 2'b10;
  localparam logic [1:0] SNS_AB   = 2'b11;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/parking_occupancy_ctrl_if.sv
// Sensor inputs, clear and occupancy outputs of the parking controller,
// bundled so the top level and its environment share one port list.
interface parking_occupancy_ctrl_if #(
  parameter int NUM_LANES = 2,
  parameter int CNT_W     = 3
);

  logic [NUM_LANES-1:0] a;
  logic [NUM_LANES-1:0] b;
  logic                 clr;
  logic [CNT_W-1:0]     count;
  logic                 full;
  logic                 empty;
  logic [NUM_LANES-1:0] entry_pulse;
  logic [NUM_LANES-1:0] exit_pulse;
  logic                 seq_err;
  logic                 sat_err;

  modport master (
    output a, b, clr,
    input  count, full, empty, entry_pulse, exit_pulse, seq_err, sat_err
  );

  modport slave (
    input  a, b, clr,
    output count, full, empty, entry_pulse, exit_pulse, seq_err, sat_err
  );

endinterface

// File: rtl/lane_dir_fsm.sv
// One sensor lane: 2-FF synchroniser and debouncer per sensor, then a
// direction FSM with a per-state timeout. Outputs are registered 1-cycle pulses.
module lane_dir_fsm
  import parking_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int SEQ_TMO    = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic entry,
  output logic exit,
  output logic err
);

  localparam int DCW = $clog2(DEB_CYCLES + 1);
  localparam int TW  = $clog2(SEQ_TMO + 1);

  logic [1:0] sns_raw;
  logic [1:0] sns_deb;

  assign sns_raw = {a_raw, b_raw};

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_cond
    logic           sync1_q, sync1_d;
    logic           sync2_q, sync2_d;
    logic           lvl_q, lvl_d;
    logic [DCW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        lvl_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
        lvl_q   <= lvl_d;
        cnt_q   <= cnt_d;
      end
    end

    // cnt_q counts consecutive samples that disagree with the accepted level
    always_comb begin
      sync1_d = sns_raw[gi];
      sync2_d = sync1_q;
      lvl_d   = lvl_q;
      cnt_d   = '0;
      if (sync2_q != lvl_q) begin
        if (int'(cnt_q) >= DEB_CYCLES - 1) begin
          lvl_d = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    assign sns_deb[gi] = lvl_q;
  end

  lane_state_e   state_q, state_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          entry_q, entry_d;
  logic          exit_q, exit_d;
  logic          err_q, err_d;
  logic          tmo_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      tmo_cnt_q <= '0;
      entry_q   <= 1'b0;
      exit_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      entry_q   <= entry_d;
      exit_q    <= exit_d;
      err_q     <= err_d;
    end
  end

  assign tmo_hit = (state_q != ST_IDLE) && (state_q != ST_ABORT) &&
                   (int'(tmo_cnt_q) >= SEQ_TMO - 1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sns_deb == SNS_A)       state_d = ST_EN1;
        else if (sns_deb == SNS_B)  state_d = ST_EX1;
        else if (sns_deb == SNS_AB) state_d = ST_ABORT;
      end
      ST_EN1: begin
        if (sns_deb == SNS_AB)        state_d = ST_EN2;
        else if (sns_deb == SNS_NONE) state_d = ST_IDLE;
        else if (sns_deb == SNS_B)    state_d = ST_ABORT;
      end
      ST_EN2: begin
        if (sns_deb == SNS_B)         state_d = ST_EN3;
        else if (sns_deb == SNS_A)    state_d = ST_EN1;
        else if (sns_deb == SNS_NONE) state_d = ST_ABORT;
      end
      ST_EN3: begin
        if (sns_deb == SNS_NONE)      state_d = ST_IDLE;
        else if (sns_deb == SNS_AB)   state_d = ST_EN2;
        else if (sns_deb == SNS_A)    state_d = ST_ABORT;
      end
      ST_EX1: begin
        if (sns_deb == SNS_AB)        state_d = ST_EX2;
        else if (sns_deb == SNS_NONE) state_d = ST_IDLE;
        else if (sns_deb == SNS_A)    state_d = ST_ABORT;
      end
      ST_EX2: begin
        if (sns_deb == SNS_A)         state_d = ST_EX3;
        else if (sns_deb == SNS_B)    state_d = ST_EX1;
        else if (sns_deb == SNS_NONE) state_d = ST_ABORT;
      end
      ST_EX3: begin
        if (sns_deb == SNS_NONE)      state_d = ST_IDLE;
        else if (sns_deb == SNS_AB)   state_d = ST_EX2;
        else if (sns_deb == SNS_B)    state_d = ST_ABORT;
      end
      ST_ABORT: begin
        if (sns_deb == SNS_NONE)      state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // a legal move in the expiring cycle still wins over the timeout
    if (tmo_hit && (state_d == state_q)) begin
      state_d = ST_ABORT;
    end
  end

  always_comb begin
    entry_d   = (state_q == ST_EN3) && (sns_deb == SNS_NONE);
    exit_d    = (state_q == ST_EX3) && (sns_deb == SNS_NONE);
    err_d     = (state_d == ST_ABORT) && (state_q != ST_ABORT);
    tmo_cnt_d = '0;
    if ((state_d == state_q) && (state_q != ST_IDLE) && (state_q != ST_ABORT)) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  assign entry = entry_q;
  assign exit  = exit_q;
  assign err   = err_q;

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Multi-lane occupancy controller: one lane_dir_fsm per sensor pair feeding a
// saturating occupancy counter with full/empty and sticky error flags.
module parking_occupancy_ctrl
  import parking_pkg::*;
#(
  parameter int NUM_LANES  = 2,
  parameter int CAPACITY   = 7,
  parameter int CNT_W      = 3,
  parameter int DEB_CYCLES = 4,
  parameter int SEQ_TMO    = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  parking_occupancy_ctrl_if.slave bus
);

  localparam int                     SW    = CNT_W + 4;
  localparam logic signed [SW-1:0]   CAP_S = SW'(CAPACITY);
  localparam logic [CNT_W-1:0]       CAP_C = CNT_W'(CAPACITY);

  logic [NUM_LANES-1:0] lane_entry, lane_exit, lane_err;
  logic [NUM_LANES-1:0] entry_pulse_q, entry_pulse_d;
  logic [NUM_LANES-1:0] exit_pulse_q, exit_pulse_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 seq_err_q, seq_err_d;
  logic                 sat_err_q, sat_err_d;
  logic [3:0]           n_in, n_out;
  logic signed [SW-1:0] sum;
  logic                 clamp;

  genvar gi;
  for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    lane_dir_fsm #(
      .DEB_CYCLES (DEB_CYCLES),
      .SEQ_TMO    (SEQ_TMO)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .a_raw (bus.a[gi]),
      .b_raw (bus.b[gi]),
      .entry (lane_entry[gi]),
      .exit  (lane_exit[gi]),
      .err   (lane_err[gi])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_pulse_q <= '0;
      exit_pulse_q  <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      seq_err_q     <= 1'b0;
      sat_err_q     <= 1'b0;
    end else begin
      entry_pulse_q <= entry_pulse_d;
      exit_pulse_q  <= exit_pulse_d;
      count_q       <= count_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      seq_err_q     <= seq_err_d;
      sat_err_q     <= sat_err_d;
    end
  end

  always_comb begin
    entry_pulse_d = lane_entry;
    exit_pulse_d  = lane_exit;
    n_in  = popcount8(8'(entry_pulse_q));
    n_out = popcount8(8'(exit_pulse_q));
    // widened signed sum so simultaneous entries/exits net out before clamping
    sum = $signed({4'b0000, count_q})
        + $signed({{CNT_W{1'b0}}, n_in})
        - $signed({{CNT_W{1'b0}}, n_out});
    clamp   = 1'b0;
    count_d = sum[CNT_W-1:0];
    if (sum > CAP_S) begin
      count_d = CAP_C;
      clamp   = 1'b1;
    end else if (sum[SW-1]) begin
      count_d = '0;
      clamp   = 1'b1;
    end
    seq_err_d = seq_err_q | (|lane_err);
    sat_err_d = sat_err_q | clamp;
    if (bus.clr) begin
      count_d   = '0;
      seq_err_d = 1'b0;
      sat_err_d = 1'b0;
    end
    full_d  = (count_d == CAP_C);
    empty_d = (count_d == '0);
  end

  assign bus.entry_pulse = entry_pulse_q;
  assign bus.exit_pulse  = exit_pulse_q;
  assign bus.count       = count_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.seq_err     = seq_err_q;
  assign bus.sat_err     = sat_err_q;

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Directed bench for parking_occupancy_ctrl: stimulus pushes expected pulses and
// counter states into queues; a negedge monitor pops and compares them.
module tb_parking_occupancy_ctrl;

  localparam int NL   = 2;
  localparam int CAP  = 7;
  localparam int CW   = 3;
  localparam int DEB  = 4;
  localparam int TMO  = 1024;
  localparam int HOLD = 10;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          full;
    logic          empty;
    logic          sat;
  } cnt_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  parking_occupancy_ctrl_if #(.NUM_LANES(NL), .CNT_W(CW)) bus ();

  parking_occupancy_ctrl #(
    .NUM_LANES  (NL),
    .CAPACITY   (CAP),
    .CNT_W      (CW),
    .DEB_CYCLES (DEB),
    .SEQ_TMO    (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  cnt_exp_t   exp_cnt_q[$];
  logic [3:0] exp_pulse_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         cnt_due = 1'b0;
  logic [1:0] ent_seq[4];
  logic [1:0] ext_seq[4];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: a pulse cycle is one transaction, the following cycle's counter state another
  always @(negedge clk) begin : mon
    cnt_exp_t   ce;
    logic [3:0] pe;
    if (cnt_due) begin
      if (exp_cnt_q.size() == 0) begin
        check("unexpected_count_update", 1, 0);
      end else begin
        ce = exp_cnt_q.pop_front();
        check("count", int'(bus.count), int'(ce.cnt));
        check("full", int'(bus.full), int'(ce.full));
        check("empty", int'(bus.empty), int'(ce.empty));
        check("sat_err", int'(bus.sat_err), int'(ce.sat));
        $display("txn count: count=%0d full=%0b empty=%0b sat_err=%0b",
                 bus.count, bus.full, bus.empty, bus.sat_err);
      end
    end
    pe = {bus.entry_pulse, bus.exit_pulse};
    cnt_due = (pe != 4'b0000);
    if (cnt_due) begin
      if (exp_pulse_q.size() == 0) begin
        check("unexpected_pulse", int'(pe), 0);
      end else begin
        check("pulses", int'(pe), int'(exp_pulse_q.pop_front()));
        $display("txn pulse: entry=%b exit=%b", bus.entry_pulse, bus.exit_pulse);
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_lane(input int lane, input logic [1:0] ab);
    bus.a[lane] = ab[1];
    bus.b[lane] = ab[0];
  endtask

  task automatic walk(input int lane, input logic [1:0] s0, input logic [1:0] s1,
                      input logic [1:0] s2, input logic [1:0] s3);
    set_lane(lane, s0); hold(HOLD);
    set_lane(lane, s1); hold(HOLD);
    set_lane(lane, s2); hold(HOLD);
    set_lane(lane, s3); hold(HOLD);
  endtask

  task automatic expect_evt(input logic [1:0] ent, input logic [1:0] ext,
                            input int cnt, input logic sat);
    cnt_exp_t ce;
    ce.cnt   = CW'(cnt);
    ce.full  = (cnt == CAP);
    ce.empty = (cnt == 0);
    ce.sat   = sat;
    exp_pulse_q.push_back({ent, ext});
    exp_cnt_q.push_back(ce);
  endtask

  task automatic do_entry(input int lane, input int cnt, input logic sat);
    logic [1:0] v;
    v = 2'b01 << lane;
    expect_evt(v, 2'b00, cnt, sat);
    walk(lane, 2'b10, 2'b11, 2'b01, 2'b00);
  endtask

  task automatic do_clr(input string tag);
    bus.clr = 1'b1;
    hold(1);
    bus.clr = 1'b0;
    check({tag, "_clr_count"}, int'(bus.count), 0);
    check({tag, "_clr_empty"}, int'(bus.empty), 1);
    check({tag, "_clr_full"}, int'(bus.full), 0);
    check({tag, "_clr_seq_err"}, int'(bus.seq_err), 0);
    check({tag, "_clr_sat_err"}, int'(bus.sat_err), 0);
    $display("txn clr: count=%0d seq_err=%0b sat_err=%0b", bus.count, bus.seq_err, bus.sat_err);
  endtask

  task automatic wait_seq_err(input string name, input int budget);
    for (int i = 0; i < budget && bus.seq_err !== 1'b1; i++) hold(1);
    check(name, int'(bus.seq_err), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ent_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    ext_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    bus.a   = '0;
    bus.b   = '0;
    bus.clr = 1'b0;
    hold(3);
    check("rst_count", int'(bus.count), 0);
    check("rst_empty", int'(bus.empty), 1);
    check("rst_full", int'(bus.full), 0);
    check("rst_seq_err", int'(bus.seq_err), 0);
    check("rst_sat_err", int'(bus.sat_err), 0);
    check("rst_pulses", int'({bus.entry_pulse, bus.exit_pulse}), 0);
    reset = 1'b1;
    hold(2);

    // single entry, then fill to capacity and overflow
    do_entry(0, 1, 1'b0);
    hold(2);
    check("t1_empty_falls", int'(bus.empty), 0);
    for (int k = 2; k <= 7; k++) do_entry(0, k, 1'b0);
    hold(2);
    check("t2_full", int'(bus.full), 1);
    do_entry(0, 7, 1'b1);
    hold(2);
    check("t2_sat_err", int'(bus.sat_err), 1);
    do_clr("t2");

    // simultaneous entry on lane0 and exit on lane1 at count 3
    for (int k = 1; k <= 3; k++) do_entry(0, k, 1'b0);
    expect_evt(2'b01, 2'b10, 3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      set_lane(0, ent_seq[i]);
      set_lane(1, ext_seq[i]);
      hold(HOLD);
    end
    hold(2);
    check("t3_count", int'(bus.count), 3);
    check("t3_no_seq_err", int'(bus.seq_err), 0);

    // reversal is silent; 00->11 aborts until 00
    walk(1, 2'b10, 2'b11, 2'b10, 2'b00);
    hold(2);
    check("t4_reversal_no_err", int'(bus.seq_err), 0);
    set_lane(1, 2'b11);
    wait_seq_err("t4_illegal_seq_err", 40);
    hold(HOLD);
    set_lane(1, 2'b00);
    hold(HOLD);
    do_entry(1, 4, 1'b0);
    do_clr("t4");

    // short glitches are ignored; long hold in EN1 times out
    set_lane(0, 2'b10); hold(3); set_lane(0, 2'b00); hold(HOLD);
    set_lane(0, 2'b11); hold(3); set_lane(0, 2'b00); hold(HOLD);
    check("t5_glitch_no_err", int'(bus.seq_err), 0);
    set_lane(0, 2'b10);
    hold(900);
    check("t5_before_timeout", int'(bus.seq_err), 0);
    wait_seq_err("t5_timeout_seq_err", 300);
    set_lane(0, 2'b11); hold(HOLD);
    set_lane(0, 2'b01); hold(HOLD);
    set_lane(0, 2'b00); hold(HOLD);
    check("t5_abort_not_counted", int'(bus.count), 0);
    do_clr("t5");
    for (int k = 1; k <= 5; k++) do_entry(0, k, 1'b0);

    // clr at count 5 while lane1 is mid-entry
    expect_evt(2'b10, 2'b00, 1, 1'b0);
    set_lane(1, 2'b10); hold(HOLD);
    set_lane(1, 2'b11); hold(HOLD);
    do_clr("t6");
    set_lane(1, 2'b01); hold(HOLD);
    set_lane(1, 2'b00); hold(HOLD);
    hold(2);
    check("t6_inflight_counted", int'(bus.count), 1);

    // async reset while lane0 is in EN2
    set_lane(0, 2'b10); hold(HOLD);
    set_lane(0, 2'b11); hold(HOLD);
    #3 reset = 1'b0;
    #1;
    check("t6_rst_count", int'(bus.count), 0);
    check("t6_rst_empty", int'(bus.empty), 1);
    check("t6_rst_full", int'(bus.full), 0);
    check("t6_rst_seq_err", int'(bus.seq_err), 0);
    check("t6_rst_pulses", int'({bus.entry_pulse, bus.exit_pulse}), 0);
    set_lane(0, 2'b00);
    hold(3);
    reset = 1'b1;
    set_lane(0, 2'b01); hold(HOLD);
    set_lane(0, 2'b00); hold(HOLD);
    check("t6_partial_not_counted", int'(bus.count), 0);
    check("t6_partial_no_err", int'(bus.seq_err), 0);
    do_entry(0, 1, 1'b0);
    hold(5);

    check("pulse_queue_drained", exp_pulse_q.size(), 0);
    check("count_queue_drained", exp_cnt_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
